// File: rtl/tia_missile_motion.sv
// tia_missile_motion: HMOVE extra-clock (mec_bar) burst generator for one missile.
// Define TIA_HMOVE_BLANK_EN to add the 8-pixel late-HBLANK extension on hmove_blank.
module tia_missile_motion (
    input  logic       clk,
    input  logic       reset,
    input  logic       hmove,
    input  logic       hmm_wr,
    input  logic [3:0] hmm_data,
    input  logic       hmclr,
    input  logic       hblank,
    output logic       mec_bar,
    output logic       hmove_active,
    output logic       hmove_blank
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t     state_q, state_d;
    logic [3:0] hmm_q, tick_cnt_q, tick_cnt_d;
    logic [1:0] phase_q;
    logic [4:0] pulse_cnt_q, pulse_cnt_d, target;
    logic       motion_en_q, motion_en_d, mec_q, mec_d, tick;

    // Flipping the sign bit maps -8..+7 onto 0..15 pulses.
    assign target       = {1'b0, ~hmm_q[3], hmm_q[2:0]};
    assign tick         = phase_q == 2'd3;
    assign mec_bar      = mec_q;
    assign hmove_active = state_q == RUN;

    always_ff @(posedge clk or posedge reset)
        if (reset) hmm_q <= '0;
        else if (hmclr) hmm_q <= '0;
        else if (hmm_wr) hmm_q <= hmm_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            tick_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            motion_en_q <= 1'b0;
            mec_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_q + 2'd1;
            tick_cnt_q  <= tick_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            motion_en_q <= motion_en_d;
            mec_q       <= mec_d;
        end

    // A strobe on a tick edge restarts the sequence and swallows that tick.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        motion_en_d = motion_en_q;
        mec_d       = 1'b1;
        if (hmove) begin
            state_d     = RUN;
            tick_cnt_d  = '0;
            pulse_cnt_d = '0;
            motion_en_d = 1'b1;
        end else if (state_q == RUN && tick) begin
            if (motion_en_q && pulse_cnt_q < target) begin
                mec_d       = 1'b0;
                pulse_cnt_d = (pulse_cnt_q == 5'd16) ? pulse_cnt_q : pulse_cnt_q + 5'd1;
            end else if (pulse_cnt_q >= target) begin
                motion_en_d = 1'b0;
            end
            tick_cnt_d = tick_cnt_q + 4'd1;
            state_d    = (tick_cnt_q == 4'd15) ? IDLE : RUN;
        end
    end

`ifdef TIA_HMOVE_BLANK_EN
    logic       late_q;
    logic [2:0] late_cnt_q;

    // Latch holds through HBLANK, then for 8 more cycles after it falls.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            late_q     <= 1'b0;
            late_cnt_q <= '0;
        end else if (hmove && hblank) begin
            late_q     <= 1'b1;
            late_cnt_q <= '0;
        end else if (late_q) begin
            if (hblank) late_cnt_q <= '0;
            else if (late_cnt_q == 3'd7) late_q <= 1'b0;
            else late_cnt_q <= late_cnt_q + 3'd1;
        end

    assign hmove_blank = hblank | late_q;
`else
    assign hmove_blank = hblank;
`endif
endmodule

// File: tb/tb_tia_missile_motion.sv
// tb_tia_missile_motion: directed vector bench for the missile HMOVE extra-clock generator.
module tb_tia_missile_motion;
    logic       clk = 1'b0, reset = 1'b1, hmove = 1'b0, hmm_wr = 1'b0, hmclr = 1'b0, hblank = 1'b0;
    logic [3:0] hmm_data = '0;
    logic       mec_bar, hmove_active, hmove_blank;
    logic [1:0] ph;
    int         total = 0, passed = 0;

    tia_missile_motion dut (
        .clk(clk), .reset(reset), .hmove(hmove), .hmm_wr(hmm_wr), .hmm_data(hmm_data),
        .hmclr(hmclr), .hblank(hblank), .mec_bar(mec_bar), .hmove_active(hmove_active),
        .hmove_blank(hmove_blank)
    );

    always #5 clk = ~clk;

    // Reference colour-clock phase: value the divider holds before the next edge.
    always @(posedge clk or posedge reset)
        if (reset) ph <= 2'd0;
        else ph <= ph + 2'd1;

    typedef struct {
        logic       wr;
        logic       clr;
        logic [3:0] d;
        int         p;
        int         n;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int span(input int p);
        return (p == 3) ? 64 : 63 - p;
    endfunction

    // act 0: write HMM=-6 after act_at pulses; act 1: re-strobe hmove after act_at pulses.
    task automatic run_seq(input logic wr, input logic clr, input logic [3:0] d, input int p,
                           input int exp_n, input int act_at, input int act, input string nm);
        int n, dur, first, last, bad, exp_dur, p2;
        logic done, rs;
        if (wr || clr) begin
            hmm_wr = wr; hmclr = clr; hmm_data = d;
            step();
            hmm_wr = 1'b0; hmclr = 1'b0;
        end
        for (int k = 0; k < 4 && int'(ph) != p; k++) step();
        exp_dur = span(int'(ph));
        hmove = 1'b1;
        step();
        hmove = 1'b0;
        n = 0; dur = 0; first = -1; last = -100; bad = 0; done = 1'b0; p2 = 0;
        while (hmove_active && dur < 200) begin
            rs = 1'b0;
            if (!mec_bar) begin
                if (n == 0) first = dur;
                else if (dur - last != 4) bad++;
                last = dur;
                n++;
            end
            if (n == act_at && !done) begin
                done = 1'b1;
                if (act == 0) begin
                    hmm_wr = 1'b1; hmm_data = 4'hA;
                end else begin
                    p2 = int'(ph); hmove = 1'b1; rs = 1'b1;
                end
            end
            dur++;
            step();
            hmm_wr = 1'b0; hmove = 1'b0;
            if (rs) begin
                last -= dur;
                dur = 0;
                exp_dur = span(p2);
            end
        end
        chk({nm, " pulses"}, n, exp_n);
        chk({nm, " active_cycles"}, dur, exp_dur);
        chk({nm, " spacing_errors"}, bad, 0);
        if (exp_n > 0 && act_at < 0) chk({nm, " first_pulse"}, first, (p == 3) ? 4 : 3 - p);
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        vecs[0] = '{1'b0, 1'b0, 4'h0, 0, 8};
        vecs[1] = '{1'b1, 1'b0, 4'h0, 1, 8};
        vecs[2] = '{1'b1, 1'b0, 4'h7, 2, 15};
        vecs[3] = '{1'b1, 1'b0, 4'h8, 3, 0};
        vecs[4] = '{1'b1, 1'b0, 4'h1, 3, 9};
        vecs[5] = '{1'b1, 1'b0, 4'hF, 0, 7};
        vecs[6] = '{1'b1, 1'b1, 4'h5, 2, 8};
        vecs[7] = '{1'b1, 1'b0, 4'hC, 1, 4};

        repeat (2) @(posedge clk);
        #1;
        chk("reset mec_bar", int'(mec_bar), 1);
        chk("reset hmove_active", int'(hmove_active), 0);
        chk("reset hmove_blank", int'(hmove_blank), 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++)
            run_seq(vecs[i].wr, vecs[i].clr, vecs[i].d, vecs[i].p, vecs[i].n, -1, 0,
                    $sformatf("row%0d", i));

        run_seq(1'b1, 1'b0, 4'h7, 0, 3, 3, 0, "midwrite");
        run_seq(1'b1, 1'b0, 4'h0, 0, 13, 5, 1, "restart");

        // Asynchronous reset while a pulse is on the output.
        hmove = 1'b1;
        step();
        hmove = 1'b0;
        for (int k = 0; k < 80 && mec_bar; k++) step();
        chk("abort pulse_seen", int'(mec_bar), 0);
        reset = 1'b1;
        #1;
        chk("abort mec_bar", int'(mec_bar), 1);
        chk("abort hmove_active", int'(hmove_active), 0);
        step();
        reset = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            n += int'(!mec_bar) + int'(hmove_active);
        end
        chk("abort quiet", n, 0);

`ifdef TIA_HMOVE_BLANK_EN
        hblank = 1'b1;
        step();
        hmove = 1'b1;
        step();
        hmove = 1'b0;
        repeat (3) step();
        hblank = 1'b0;
        n = 0;
        while (hmove_blank && n < 30) begin
            n++;
            step();
        end
        chk("late_blank cycles", n, 8);
        hmove = 1'b1;
        step();
        hmove = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            n += int'(hmove_blank);
            step();
        end
        chk("no_blank outside hblank", n, 0);
`else
        for (int k = 0; k < 12; k++) begin
            hblank = k[1];
            hmove = (k == 3 || k == 8);
            step();
            hmove = 1'b0;
            chk($sformatf("blank_passthru%0d", k), int'(hmove_blank), int'(k[1]));
        end
`endif
        repeat (70) step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
